vc_output_rr_arb: RTL and testbench
===================================

// Module: vc_output_rr_arb
// PURPOSE
// Per-output-port VC arbiter. It selects one of N_REQ granted virtual channels
// to drive the output link each cycle.
// It is the parametrised successor of the fixed-priority output VC selector and
// adds three things:
// - round-robin fairness, with a selectable fixed-priority mode;
// - wormhole packet locking from head flit to tail flit;
// - downstream-ready gating.
// It sits between VC allocation and the output crossbar mux of each router port.
// PARAMETERS
// LOCAL_PORT    E          dir_t output port this instance serves (debug/assert messages only)
// N_REQ         NUM_VCS    number of requesting VCs, >=1
// MODE          ARB_RR     arb_mode_t: ARB_FIXED (VC0 highest, always) or ARB_RR
// LOCK_PACKETS  1          1: hold selection from first non-tail transfer to tail; 0: per-flit arbitration
// PORTS
// clk              in   1                 router clock
// rst_n            in   1                 asynchronous active-low reset
// LOCAL_X/LOCAL_Y  in   DIM_BITS          router coordinates; present only under `ifndef SYNTHESIS, debug prints only
// vc_granted       in   [N_REQ] (unpacked) VC i has a flit and a granted output VC this cycle
// vc_tail          in   [N_REQ] (unpacked) flit offered by VC i is a tail (head+tail = single-flit packet)
// out_ready        in   1                 downstream credit available / link free this cycle
// out_vc_selected  out  [N_REQ] (unpacked) one-hot (or zero) select; asserted means a flit transfers this cycle
// out_vc_id        out  VC_ID_BITS        encoded index of the selected VC; 0 when none is selected
// out_valid        out  1                 OR of out_vc_selected
// locked           out  1                 a packet currently owns the port
// BEHAVIOUR
// - Reset: async on rst_n low. rr_ptr=0, locked=0, lock_vc=0.
//   - out_vc_selected is all-0 and out_valid=0 while rst_n=0 (forced, regardless of inputs).
//   - Reset mid-packet drops the lock. It is legal for upstream to be reset simultaneously.
// - Latency: selection is combinational from inputs plus state (0 cycles). State updates on the clk rising edge.
// - Transfer: xfer = out_valid. out_vc_selected is only nonzero when out_ready=1.
//   - With out_ready=0 there is no selection and no state change.
// - Eligibility:
//   - Unlocked: elig = vc_granted.
//   - Locked: elig = vc_granted & onehot(lock_vc). Other VCs are masked even if the owner idles.
//     This is a wormhole bubble; the port is never handed over mid-packet.
// - Pick among elig:
//   - ARB_FIXED: lowest index wins. rr_ptr stays 0 (matches the legacy selector).
//   - ARB_RR: first eligible index at or after rr_ptr, wrapping N_REQ-1 -> 0.
// - State machine (LOCK_PACKETS=1): two states, IDLE and LOCKED.
//   - IDLE: a transfer from VC k with vc_tail[k]=0 moves to LOCKED with lock_vc=k.
//     A transfer with vc_tail[k]=1 stays in IDLE.
//   - LOCKED: a transfer from lock_vc with tail=1 returns to IDLE.
//     A non-tail transfer stays in LOCKED.
// - Pointer update (ARB_RR only): on a transfer that ends arbitration ownership, rr_ptr <= (k+1) mod N_REQ.
//   - With LOCK_PACKETS=1 this is a tail transfer; with LOCK_PACKETS=0 it is any transfer.
//   - Use explicit compare-and-wrap, not a power-of-2 mask, so that N_REQ is any value >= 1.
// - LOCK_PACKETS=0: the state machine is held in IDLE and locked stays 0.
// - N_REQ=1: out_vc_selected[0] = vc_granted[0] & out_ready & rst_n. rr_ptr is a constant 0.
// - Assertions (non-synth):
//   - out_vc_selected is $onehot0.
//   - When locked, out_vc_selected is never set for a VC other than lock_vc.
//   - vc_tail is ignored unless the corresponding bit is selected.
// STRUCTURE
// - router_pkg additions:
//   - typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
//   - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
//   - NUM_VCS, VC_ID_BITS and dir_t are used from the existing package.
// - Sub-module rr_prio_select #(N): combinational, inputs req[N] and ptr; outputs one-hot gnt[N] and idx.
//   It uses a masked/unmasked double priority-encode.
//   ARB_FIXED instantiates it with ptr tied to 0.
// - Top: state registers (state, lock_vc, rr_ptr), eligibility masking, ready/reset gating, and the encoder.
// TESTING
// Default config for tests: N_REQ=4, ARB_RR, LOCK_PACKETS=1, out_ready=1 unless stated otherwise.
// 1. Fairness: all 4 vc_granted=1, every tail=1, 8 cycles -> grants VC 0,1,2,3,0,1,2,3; locked stays 0.
// 2. Lock: VC2 sends a 3-flit packet (tails 0,0,1) while VC0/VC1 request continuously.
//    -> VC2 is selected for 3 transfers and locked=1 for the 2nd and 3rd.
//    -> The next grant goes to VC3 if it requests, else VC0.
// 3. Bubble: locked on VC1, VC1 drops vc_granted for 2 cycles while VC0 requests.
//    -> out_valid=0 for those 2 cycles; VC1 resumes with the lock intact.
// 4. Backpressure: out_ready=0 for 3 cycles mid-packet with requests held.
//    -> out_vc_selected=0; rr_ptr and lock are unchanged; selection resumes when out_ready returns to 1.
// 5. Wrap/fixed mode:
//    - ARB_RR, rr_ptr=3, only VC1 requests -> VC1 is selected and rr_ptr becomes 2.
//    - ARB_FIXED, VC1 and VC3 request -> VC1 wins every cycle.
// 6. Reset mid-packet: assert rst_n=0 asynchronously (between edges) while locked on VC3.
//    -> Outputs go to 0 immediately; after release, locked=0 and VC0 is granted first.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router sizes and types
// Purpose: VC count, index widths, port directions and the output arbiter's
// mode/state enums, imported by every router block.
// Ports: none (package).
package router_pkg;

    localparam int NUM_VCS    = 4;
    localparam int VC_ID_BITS = 2;
    localparam int DIM_BITS   = 3;

    typedef enum logic [2:0] {
        DIR_N,
        DIR_E,
        DIR_S,
        DIR_W,
        DIR_L
    } dir_t;

    // ARB_FIXED: VC0 always highest priority. ARB_RR: rotating priority.
    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_prio_select.sv
// rtl/rr_prio_select.sv - rotating priority select among N requesters
// Purpose: picks the first asserted req at or after ptr, wrapping to 0.
// Ports:
//   req  in  [N]   request vector
//   ptr  in  [PW]  highest-priority index this cycle
//   gnt  out [N]   one-hot (or zero) grant
//   idx  out [PW]  encoded grant index, 0 when nothing is granted
module rr_prio_select #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;

    // First pass searches only indices >= ptr; the second pass covers the
    // wrap-around. Compare-based masking keeps any N legal.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        gnt   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr)) begin
                found = 1'b1;
                idx   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = found && (PW'(i) == idx);
        end
    end

endmodule

// File: rtl/vc_output_rr_arb.sv
// rtl/vc_output_rr_arb.sv - per-output-port VC arbiter with wormhole locking
// Purpose: selects one granted VC per cycle to drive the output link, with
// round-robin or fixed priority, head-to-tail packet locking and
// downstream-ready gating. Selection is combinational; state moves on clk.
// Ports:
//   clk, rst_n         router clock, async active-low reset
//   LOCAL_X/LOCAL_Y    router coordinates (debug messages only, non-synth)
//   vc_granted[N_REQ]  VC i offers a flit with an allocated output VC
//   vc_tail[N_REQ]     flit offered by VC i is a tail
//   out_ready          downstream can accept a flit this cycle
//   out_vc_selected    one-hot (or zero) select; set means a flit transfers
//   out_vc_id          encoded selected VC, 0 when none
//   out_valid          a flit transfers this cycle
//   locked             a packet currently owns the port
module vc_output_rr_arb
    import router_pkg::*;
#(
    parameter dir_t      LOCAL_PORT   = DIR_E,
    parameter int        N_REQ        = NUM_VCS,
    parameter arb_mode_t MODE         = ARB_RR,
    parameter bit        LOCK_PACKETS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifndef SYNTHESIS
    input  logic [DIM_BITS-1:0]   LOCAL_X,
    input  logic [DIM_BITS-1:0]   LOCAL_Y,
`endif
    input  logic                  vc_granted      [N_REQ],
    input  logic                  vc_tail         [N_REQ],
    input  logic                  out_ready,
    output logic                  out_vc_selected [N_REQ],
    output logic [VC_ID_BITS-1:0] out_vc_id,
    output logic                  out_valid,
    output logic                  locked
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q;
    logic             locked_q;
    logic [PW-1:0]    lock_vc_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [PW-1:0]    rr_ptr_d;

    logic [N_REQ-1:0] req_vec;
    logic [N_REQ-1:0] tail_vec;
    logic [N_REQ-1:0] lock_mask;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] sel;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    ptr_eff;
    logic             xfer;
    logic             sel_tail;

    always_comb begin
        req_vec   = '0;
        tail_vec  = '0;
        lock_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_vec[i]   = vc_granted[i];
            tail_vec[i]  = vc_tail[i];
            lock_mask[i] = (PW'(i) == lock_vc_q);
        end
    end

    // While a packet owns the port every other VC is masked, even when the
    // owner has nothing to send: the port idles rather than interleave flits.
    assign elig    = (state_q == ARB_LOCKED) ? (req_vec & lock_mask) : req_vec;
    assign ptr_eff = (MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_prio_select #(.N(N_REQ)) u_prio (
        .req (elig),
        .ptr (ptr_eff),
        .gnt (gnt),
        .idx (pick_idx)
    );

    // Reset is folded in combinationally so the link is quiet the instant
    // rst_n drops, not at the next edge.
    assign sel      = (out_ready && rst_n) ? gnt : '0;
    assign xfer     = |sel;
    assign sel_tail = |(sel & tail_vec);

    assign rr_ptr_d = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            locked_q  <= 1'b0;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
        end else if (xfer) begin
            if (LOCK_PACKETS) begin
                unique case (state_q)
                    ARB_IDLE: begin
                        if (!sel_tail) begin
                            state_q   <= ARB_LOCKED;
                            locked_q  <= 1'b1;
                            lock_vc_q <= pick_idx;
                        end
                    end
                    ARB_LOCKED: begin
                        if (sel_tail) begin
                            state_q  <= ARB_IDLE;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ARB_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // The pointer only rotates when ownership ends, so a long packet
            // does not cost its successor a turn.
            if ((MODE == ARB_RR) && (sel_tail || !LOCK_PACKETS)) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    always_comb begin
        out_vc_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            out_vc_selected[i] = sel[i];
            if (sel[i]) begin
                out_vc_id = VC_ID_BITS'(i);
            end
        end
    end

    assign out_valid = xfer;
    assign locked    = locked_q;

`ifndef SYNTHESIS
    logic          hold_chk_q;
    arb_state_t    state_prev_q;
    logic [PW-1:0] ptr_prev_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_chk_q <= 1'b0;
        end else begin
            assert ($onehot0(sel))
                else $error("arb port %0d (%0d,%0d): several VCs selected", LOCAL_PORT, LOCAL_X, LOCAL_Y);
            if (state_q == ARB_LOCKED) begin
                assert ((sel & ~lock_mask) == '0)
                    else $error("arb port %0d (%0d,%0d): non-owner selected while locked", LOCAL_PORT, LOCAL_X, LOCAL_Y);
            end
            // Without a transfer no tail bit may have moved the state.
            if (hold_chk_q) begin
                assert ((state_q == state_prev_q) && (rr_ptr_q == ptr_prev_q))
                    else $error("arb port %0d (%0d,%0d): state changed without transfer", LOCAL_PORT, LOCAL_X, LOCAL_Y);
            end
            hold_chk_q   <= !xfer;
            state_prev_q <= state_q;
            ptr_prev_q   <= rr_ptr_q;
        end
    end
`endif

endmodule

// File: tb/tb_vc_output_rr_arb.sv
// tb/tb_vc_output_rr_arb.sv - scoreboard bench for vc_output_rr_arb
module tb_vc_output_rr_arb;
    import router_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic out_ready;
    logic g4 [4];
    logic t4 [4];
    logic g3 [3];
    logic t3 [3];
    logic [DIM_BITS-1:0] lx;
    logic [DIM_BITS-1:0] ly;

    logic s0 [4];
    logic s1 [4];
    logic s2 [4];
    logic s3 [3];
    logic [VC_ID_BITS-1:0] id0, id1, id2, id3;
    logic v0, v1, v2, v3;
    logic l0, l1, l2, l3;

    // cfg0: RR+lock, cfg1: FIXED+lock, cfg2: RR per-flit, cfg3: 3 VCs RR+lock
    vc_output_rr_arb #(.LOCAL_PORT(DIR_E), .N_REQ(4), .MODE(ARB_RR), .LOCK_PACKETS(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
`ifndef SYNTHESIS
        .LOCAL_X(lx), .LOCAL_Y(ly),
`endif
        .vc_granted(g4), .vc_tail(t4), .out_ready(out_ready),
        .out_vc_selected(s0), .out_vc_id(id0), .out_valid(v0), .locked(l0));

    vc_output_rr_arb #(.LOCAL_PORT(DIR_N), .N_REQ(4), .MODE(ARB_FIXED), .LOCK_PACKETS(1'b1)) u_fix (
        .clk(clk), .rst_n(rst_n),
`ifndef SYNTHESIS
        .LOCAL_X(lx), .LOCAL_Y(ly),
`endif
        .vc_granted(g4), .vc_tail(t4), .out_ready(out_ready),
        .out_vc_selected(s1), .out_vc_id(id1), .out_valid(v1), .locked(l1));

    vc_output_rr_arb #(.LOCAL_PORT(DIR_S), .N_REQ(4), .MODE(ARB_RR), .LOCK_PACKETS(1'b0)) u_nolock (
        .clk(clk), .rst_n(rst_n),
`ifndef SYNTHESIS
        .LOCAL_X(lx), .LOCAL_Y(ly),
`endif
        .vc_granted(g4), .vc_tail(t4), .out_ready(out_ready),
        .out_vc_selected(s2), .out_vc_id(id2), .out_valid(v2), .locked(l2));

    vc_output_rr_arb #(.LOCAL_PORT(DIR_W), .N_REQ(3), .MODE(ARB_RR), .LOCK_PACKETS(1'b1)) u_n3 (
        .clk(clk), .rst_n(rst_n),
`ifndef SYNTHESIS
        .LOCAL_X(lx), .LOCAL_Y(ly),
`endif
        .vc_granted(g3), .vc_tail(t3), .out_ready(out_ready),
        .out_vc_selected(s3), .out_vc_id(id3), .out_valid(v3), .locked(l3));

    typedef struct packed {
        logic [15:0] sel;
        logic [3:0]  lk;
    } exp_t;

    exp_t sb [$];
    exp_t me;

    int owner  [4];
    int ptr    [4];
    int cfg_n  [4] = '{4, 4, 4, 3};
    bit cfg_rr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit cfg_lk [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    int checks = 0;
    int passes = 0;

    // Reference: an owner VC (or -1) and a "next favoured" index per config.
    function automatic int model_pick(input int c, input logic [3:0] g);
        if (owner[c] >= 0) return g[owner[c]] ? owner[c] : -1;
        for (int o = 0; o < cfg_n[c]; o++) begin
            int k;
            k = cfg_rr[c] ? (ptr[c] + o) % cfg_n[c] : o;
            if (g[k]) return k;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] g, input logic [3:0] t, input logic rdy,
                        input logic rst_v, input bit mid);
        exp_t e;
        int   p;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            g4[i] = g[i];
            t4[i] = t[i];
        end
        for (int i = 0; i < 3; i++) begin
            g3[i] = g[i];
            t3[i] = t[i];
        end
        out_ready = rdy;
        if (mid) #2;
        rst_n = rst_v;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            if (!rst_v) begin
                owner[c] = -1;
                ptr[c]   = 0;
            end else begin
                e.lk[c] = (owner[c] >= 0);
                p = rdy ? model_pick(c, g) : -1;
                if (p >= 0) begin
                    e.sel[c*4 + p] = 1'b1;
                    if (t[p] || !cfg_lk[c]) begin
                        owner[c] = -1;
                        if (cfg_rr[c]) ptr[c] = (p + 1) % cfg_n[c];
                    end else begin
                        owner[c] = p;
                    end
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic check_cfg(input int c, input logic [3:0] sel, input logic [VC_ID_BITS-1:0] id,
                             input logic v, input logic lk, input exp_t e);
        logic [3:0] es;
        int         eid;
        es  = e.sel[c*4 +: 4];
        eid = 0;
        for (int k = 0; k < 4; k++) if (es[k]) eid = k;
        cmp($sformatf("cfg%0d sel", c), {28'd0, sel}, {28'd0, es});
        cmp($sformatf("cfg%0d id", c), {30'd0, id}, eid);
        cmp($sformatf("cfg%0d valid", c), {31'd0, v}, {31'd0, |es});
        cmp($sformatf("cfg%0d locked", c), {31'd0, lk}, {31'd0, e.lk[c]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                me = sb.pop_front();
                check_cfg(0, {s0[3], s0[2], s0[1], s0[0]}, id0, v0, l0, me);
                check_cfg(1, {s1[3], s1[2], s1[1], s1[0]}, id1, v1, l1, me);
                check_cfg(2, {s2[3], s2[2], s2[1], s2[0]}, id2, v2, l2, me);
                check_cfg(3, {1'b0, s3[2], s3[1], s3[0]}, id3, v3, l3, me);
            end
        end
    end

    initial begin
        int          wait_cnt;
        logic [3:0]  rg, rt;
        logic        rr;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        lx        = 3'd1;
        ly        = 3'd2;
        for (int i = 0; i < 4; i++) begin
            g4[i] = 1'b1;
            t4[i] = 1'b1;
            owner[i] = -1;
            ptr[i]   = 0;
        end
        for (int i = 0; i < 3; i++) begin
            g3[i] = 1'b1;
            t3[i] = 1'b1;
        end

        // Held in reset with every VC requesting: outputs forced quiet.
        step(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        step(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);

        // Fairness: single-flit packets from all VCs.
        for (int i = 0; i < 8; i++) step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);

        // Lock: move the pointer to VC2, then a 3-flit packet, then VC3 next.
        step(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'b0111, 4'b0011, 1'b1, 1'b1, 1'b0);
        step(4'b0111, 4'b0011, 1'b1, 1'b1, 1'b0);
        step(4'b0111, 4'b0111, 1'b1, 1'b1, 1'b0);
        step(4'b1011, 4'hF, 1'b1, 1'b1, 1'b0);

        // Bubble: VC1 owns the port, idles two cycles while VC0 waits.
        step(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0001, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'b0001, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0011, 4'b0010, 1'b1, 1'b1, 1'b0);

        // Backpressure mid-packet.
        step(4'hF, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'hF, 4'b0000, 1'b0, 1'b1, 1'b0);
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);

        // Wrap: pointer to 3, lone VC1 request, then all request.
        step(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1010, 4'hF, 1'b1, 1'b1, 1'b0);

        // Reset between edges while a packet owns the port.
        step(4'b1000, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'hF, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'hF, 4'b0000, 1'b1, 1'b0, 1'b1);
        step(4'hF, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'hF, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional backpressure and resets.
        for (int i = 0; i < 400; i++) begin
            rg = 4'($urandom);
            rt = 4'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 79) == 0) begin
                step(rg, rt, rr, 1'b0, 1'b1);
            end else begin
                step(rg, rt, rr, 1'b1, 1'b0);
            end
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        cmp("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
